ats21_arbiter: RTL and testbench

//   Shares one ATS21 device between N_REQ requesters.

---
 rtl/ats21_arbiter.sv | 146 ++++++++++++++
 tb/tb_ats21_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ats21_arbiter.sv
// rtl/ats21_arbiter.sv - round-robin arbiter sharing one ATS21 device among N_REQ clients
// One transaction in flight: grant, issue req, wait for ready or timeout, return result.
module ats21_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        cli_req,
    input  logic [N_REQ*CTRL_W-1:0] cli_ctrlA,
    input  logic [N_REQ*CTRL_W-1:0] cli_ctrlB,
    output logic [N_REQ-1:0]        cli_gnt,
    output logic [N_REQ-1:0]        cli_done,
    output logic [1:0]              cli_stat,
    output logic [DATA_W-1:0]       cli_data,
    output logic                    cli_tmo,
    output logic                    ats_req,
    output logic [CTRL_W-1:0]       ats_ctrlA,
    output logic [CTRL_W-1:0]       ats_ctrlB,
    input  logic                    ats_ready,
    input  logic [1:0]              ats_stat,
    input  logic [DATA_W-1:0]       ats_data
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state, state_nx;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_nx;
    logic [PTR_W-1:0]    owner, owner_nx;
    logic [PTR_W-1:0]    winner;
    logic                found;
    int                  idx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [N_REQ-1:0]    gnt_nx, done_nx;
    logic [1:0]          stat_nx;
    logic [DATA_W-1:0]   data_nx;
    logic                tmo_nx, req_nx;
    logic [CTRL_W-1:0]   ctrla_nx, ctrlb_nx;

    // Scan downwards so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (cli_req[PTR_W'(idx)]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        owner_nx  = owner;
        timer_nx  = timer;
        gnt_nx    = cli_gnt;
        done_nx   = cli_done;
        stat_nx   = cli_stat;
        data_nx   = cli_data;
        tmo_nx    = cli_tmo;
        req_nx    = ats_req;
        ctrla_nx  = ats_ctrlA;
        ctrlb_nx  = ats_ctrlB;
        case (state)
            S_IDLE: begin
                if (found) begin
                    owner_nx = winner;
                    ctrla_nx = cli_ctrlA[int'(winner)*CTRL_W +: CTRL_W];
                    ctrlb_nx = cli_ctrlB[int'(winner)*CTRL_W +: CTRL_W];
                    gnt_nx   = N_REQ'(1) << winner;
                    req_nx   = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gnt_nx   = '0;
                req_nx   = 1'b0;
                timer_nx = '0;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // Saturate rather than wrap; WAIT is left at TMR_MAX anyway.
                if (timer != TMR_MAX) timer_nx = timer + 1'b1;
                if (ats_ready) begin
                    stat_nx  = ats_stat;
                    data_nx  = ats_data;
                    tmo_nx   = 1'b0;
                    done_nx  = N_REQ'(1) << owner;
                    state_nx = S_RESP;
                end else if (timer == TMR_MAX) begin
                    stat_nx  = 2'b11;
                    data_nx  = '0;
                    tmo_nx   = 1'b1;
                    done_nx  = N_REQ'(1) << owner;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                done_nx   = '0;
                tmo_nx    = 1'b0;
                rr_ptr_nx = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            timer     <= '0;
            cli_gnt   <= '0;
            cli_done  <= '0;
            cli_stat  <= '0;
            cli_data  <= '0;
            cli_tmo   <= 1'b0;
            ats_req   <= 1'b0;
            ats_ctrlA <= '0;
            ats_ctrlB <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            owner     <= owner_nx;
            timer     <= timer_nx;
            cli_gnt   <= gnt_nx;
            cli_done  <= done_nx;
            cli_stat  <= stat_nx;
            cli_data  <= data_nx;
            cli_tmo   <= tmo_nx;
            ats_req   <= req_nx;
            ats_ctrlA <= ctrla_nx;
            ats_ctrlB <= ctrlb_nx;
        end
    end
endmodule

// File: tb/tb_ats21_arbiter.sv
// tb/tb_ats21_arbiter.sv - self-checking bench for ats21_arbiter
module tb_ats21_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cli_req;
    logic [63:0] cli_ctrlA, cli_ctrlB;
    logic [3:0]  cli_gnt, cli_done;
    logic [1:0]  cli_stat;
    logic [23:0] cli_data;
    logic        cli_tmo, ats_req;
    logic [15:0] ats_ctrlA, ats_ctrlB;
    logic        ats_ready;
    logic [1:0]  ats_stat;
    logic [23:0] ats_data;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;

    ats21_arbiter #(.N_REQ(4), .CTRL_W(16), .DATA_W(24), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cli_req(cli_req), .cli_ctrlA(cli_ctrlA), .cli_ctrlB(cli_ctrlB),
        .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_stat(cli_stat), .cli_data(cli_data),
        .cli_tmo(cli_tmo), .ats_req(ats_req), .ats_ctrlA(ats_ctrlA), .ats_ctrlB(ats_ctrlB),
        .ats_ready(ats_ready), .ats_stat(ats_stat), .ats_data(ats_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        int          dly;    // WAIT edges before ready; -1 = never ready
        logic [1:0]  st;
        logic [23:0] dt;
        logic [15:0] ca;
        logic [15:0] cb;
        int          win;
        bit          stray;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference round-robin choice: first requester at rr, rr+1, ... modulo 4.
    function automatic int model_winner(input logic [3:0] req, input int rr);
        int k;
        for (int o = 0; o < 4; o++) begin
            k = (rr + o) % 4;
            if (req[k[1:0]]) return k;
        end
        return -1;
    endfunction

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic do_txn(input string nm, input logic [3:0] req, input int dly,
                          input logic [1:0] st, input logic [23:0] dt,
                          input logic [15:0] ca, input logic [15:0] cb,
                          input int w, input bit stray);
        int  j;
        bit  got;
        bit  tmo;
        int  exp_j;
        tmo   = (dly < 0);
        exp_j = tmo ? 63 : dly;
        for (int i = 0; i < 4; i++) begin
            cli_ctrlA[i*16 +: 16] = 16'($urandom);
            cli_ctrlB[i*16 +: 16] = 16'($urandom);
        end
        cli_ctrlA[w*16 +: 16] = ca;
        cli_ctrlB[w*16 +: 16] = cb;
        cli_req = req;
        @(negedge clk);
        check({nm, " gnt"}, 64'(cli_gnt), 64'(4'b0001 << w));
        check({nm, " ats_req"}, 64'(ats_req), 64'd1);
        check({nm, " ctrlA"}, 64'(ats_ctrlA), 64'(ca));
        check({nm, " ctrlB"}, 64'(ats_ctrlB), 64'(cb));
        cli_req   = 4'b0000;
        cli_ctrlA = {$urandom, $urandom};
        cli_ctrlB = {$urandom, $urandom};
        ats_ready = stray;
        ats_stat  = 2'($urandom);
        ats_data  = 24'($urandom);
        @(negedge clk);
        ats_ready = 1'b0;
        check({nm, " issue pulses low"}, {cli_gnt, cli_done, 3'b000, ats_req}, 64'd0);
        got = 1'b0;
        j   = 0;
        while (!got && j < 100) begin
            ats_ready = (j == dly);
            ats_stat  = (j == dly) ? st : 2'($urandom);
            ats_data  = (j == dly) ? dt : 24'($urandom);
            @(negedge clk);
            ats_ready = 1'b0;
            if (cli_done != 4'b0000) got = 1'b1;
            else j++;
        end
        check({nm, " done latency"}, 64'(j), 64'(exp_j));
        check({nm, " done"}, 64'(cli_done), 64'(4'b0001 << w));
        check({nm, " stat"}, 64'(cli_stat), tmo ? 64'd3 : 64'(st));
        check({nm, " data"}, 64'(cli_data), tmo ? 64'd0 : 64'(dt));
        check({nm, " tmo"}, 64'(cli_tmo), 64'(tmo));
        check({nm, " ctrlA held"}, 64'(ats_ctrlA), 64'(ca));
        @(negedge clk);
        check({nm, " resp clears"}, {cli_done, 3'b000, cli_tmo}, 64'd0);
        check({nm, " result held"}, {cli_stat, cli_data}, tmo ? {2'b11, 24'd0} : {st, dt});
        check({nm, " ctrlB held"}, 64'(ats_ctrlB), 64'(cb));
        model_rr = (w + 1) % 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int r, d, w;
        logic [3:0] rq;

        tbl[0]  = '{4'b0100,  1, 2'b01, 24'h00BEEF, 16'h1234, 16'hABCD, 2, 1'b0};
        tbl[1]  = '{4'b1111,  0, 2'b10, 24'h000001, 16'h1111, 16'h2222, 3, 1'b0};
        tbl[2]  = '{4'b1111,  0, 2'b00, 24'h000002, 16'h3333, 16'h4444, 0, 1'b0};
        tbl[3]  = '{4'b1111,  0, 2'b11, 24'h000003, 16'h5555, 16'h6666, 1, 1'b0};
        tbl[4]  = '{4'b1111,  0, 2'b01, 24'h000004, 16'h7777, 16'h8888, 2, 1'b0};
        tbl[5]  = '{4'b1111,  0, 2'b10, 24'h000005, 16'h9999, 16'hAAAA, 3, 1'b0};
        tbl[6]  = '{4'b0001, -1, 2'b00, 24'h123456, 16'hBBBB, 16'hCCCC, 0, 1'b0};
        tbl[7]  = '{4'b0011,  2, 2'b01, 24'h654321, 16'hDDDD, 16'hEEEE, 1, 1'b0};
        tbl[8]  = '{4'b0001,  5, 2'b10, 24'hFFFFFF, 16'h0F0F, 16'hF0F0, 0, 1'b0};
        tbl[9]  = '{4'b1000, 63, 2'b01, 24'hABCDEF, 16'hCAFE, 16'hBEEF, 3, 1'b0};
        tbl[10] = '{4'b0110,  3, 2'b00, 24'h0A0B0C, 16'hFACE, 16'hD00D, 1, 1'b1};

        reset = 1'b1; cli_req = '0; cli_ctrlA = '0; cli_ctrlB = '0;
        ats_ready = 1'b0; ats_stat = '0; ats_data = '0;

        // Reset held with the clock running
        #32;
        check("reset outputs", {cli_gnt, cli_done, cli_stat, cli_tmo, ats_req}, 64'd0);
        check("reset data/ctrl", {cli_data, ats_ctrlA, ats_ctrlB}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ats_req || cli_gnt != 4'b0000) seen = 1'b1;
        end
        check("idle no req", 64'(seen), 64'd0);

        for (int i = 0; i < 11; i++)
            do_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].dly, tbl[i].st, tbl[i].dt,
                   tbl[i].ca, tbl[i].cb, tbl[i].win, tbl[i].stray);

        // Stray ready in IDLE
        ats_ready = 1'b1;
        @(negedge clk);
        ats_ready = 1'b0;
        check("stray idle", {cli_done, 3'b000, ats_req}, 64'd0);
        @(negedge clk);
        check("stray idle later", 64'(cli_done), 64'd0);
        do_txn("stray issue", 4'b1001, 2, 2'b10, 24'h13579B, 16'h0246, 16'h8ACE,
               model_winner(4'b1001, model_rr), 1'b1);

        // Reset asserted mid-cycle during WAIT
        cli_req = 4'b0100; cli_ctrlA = {4{16'h5A5A}}; cli_ctrlB = {4{16'hA5A5}};
        @(negedge clk);
        cli_req = 4'b0000;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst wait pulses", {cli_gnt, cli_done, 3'b000, ats_req}, 64'd0);
        check("rst wait ctrl", {ats_ctrlA, ats_ctrlB}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cli_done != 4'b0000) seen = 1'b1;
        end
        check("rst no done", 64'(seen), 64'd0);
        model_rr = 0;
        do_txn("rst regrant", 4'b1010, 0, 2'b01, 24'h000777, 16'h1357, 16'h2468, 1, 1'b0);

        // Randomised traffic against the round-robin model
        for (int n = 0; n < 30; n++) begin
            rq = 4'($urandom_range(1, 15));
            r  = $urandom_range(0, 9);
            d  = (r < 8) ? $urandom_range(0, 4) : ((r == 8) ? -1 : 63);
            w  = model_winner(rq, model_rr);
            do_txn($sformatf("rnd%0d", n), rq, d, 2'($urandom), 24'($urandom),
                   16'($urandom), 16'($urandom), w, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
